pred_update_sched: RTL

//  Schedules training traffic into the branch predictor's single update port set.

---
 rtl/pred_update_sched.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/pred_update_sched.sv
// pred_update_sched: funnels up to two retired conditional branches per cycle
// into the predictor's single direction-update port, and registers the
// mispredict repair port. Sits between commit and the branch predictor.
//
// Latency: a queued entry reaches the update port at the earliest the cycle
// after it is pushed (there is no bypass of an empty queue). The repair path
// is a one-cycle register.
//
// Backpressure: ret_ready is low when fewer than two slots are free. Pushes
// that do not fit are dropped, lane1 before lane0. The predictor never stalls,
// so the head entry pops every cycle the queue is non-empty.
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   ret_*_0 / ret_*_1          retire lanes (lane0 is older)
//   ret_ready                  commit may present both lanes this cycle
//   mis_*                      mispredict resolution from the backend
//   update_orien_en, retire_pc, right_orien        direction update to pred
//   branch_mistaken, wrong_pc, right_target, ins_type_w   BTB repair to pred
//   perf_drop, perf_full       performance counters
//
// Optional feature: define PRED_UPD_PERF_EN to build the saturating perf
// counters. Without it, perf_drop/perf_full are tied to zero.

module pred_update_sched #(
  parameter int DEPTH = 8,
  parameter int CNTW  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ret_valid_0,
  input  logic              ret_cond_0,
  input  logic [31:0]       ret_pc_0,
  input  logic              ret_taken_0,
  input  logic              ret_valid_1,
  input  logic              ret_cond_1,
  input  logic [31:0]       ret_pc_1,
  input  logic              ret_taken_1,
  output logic              ret_ready,
  input  logic              mis_valid,
  input  logic [31:0]       mis_pc,
  input  logic [31:0]       mis_target,
  input  logic [2:0]        mis_type,
  output logic              update_orien_en,
  output logic [31:0]       retire_pc,
  output logic              right_orien,
  output logic              branch_mistaken,
  output logic [31:0]       wrong_pc,
  output logic [31:0]       right_target,
  output logic [2:0]        ins_type_w,
  output logic [CNTW-1:0]   perf_drop,
  output logic [CNTW-1:0]   perf_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // Queue storage and pointers
  logic [31:0]      pc_q [DEPTH];
  logic [31:0]      pc_d [DEPTH];
  logic [DEPTH-1:0] taken_q, taken_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  // Repair register
  logic             mis_vld_q, mis_vld_d;
  logic [31:0]      mis_pc_q, mis_pc_d;
  logic [31:0]      mis_tgt_q, mis_tgt_d;
  logic [2:0]       mis_type_q, mis_type_d;

  // Push/pop decode
  logic             req0, req1;
  logic             acc0, acc1;
  logic             pop;
  logic [CW-1:0]    free_slots;
  logic [PW-1:0]    wr1_ptr;

  always_comb begin
    req0       = ret_valid_0 & ret_cond_0;
    req1       = ret_valid_1 & ret_cond_1;
    // Free slots come from the registered count only; the slot vacated by
    // this cycle's pop is not reused until next cycle, which keeps
    // ret_ready free of any combinational path from the inputs.
    free_slots = DEPTH_C - count_q;
    acc0       = req0 & (free_slots >= CW'(1));
    // Lane1 needs a slot beyond the one lane0 is asking for.
    acc1       = req1 & (free_slots >= (req0 ? CW'(2) : CW'(1)));
    pop        = (count_q != '0);

    pc_d    = pc_q;
    taken_d = taken_q;
    wr1_ptr = tail_q + PW'(acc0);
    if (acc0) begin
      pc_d[tail_q]    = ret_pc_0;
      taken_d[tail_q] = ret_taken_0;
    end
    if (acc1) begin
      pc_d[wr1_ptr]    = ret_pc_1;
      taken_d[wr1_ptr] = ret_taken_1;
    end
    tail_d  = wr1_ptr + PW'(acc1);
    head_d  = head_q + PW'(pop);
    count_d = count_q + CW'(acc0) + CW'(acc1) - CW'(pop);

    mis_vld_d  = mis_valid;
    mis_pc_d   = mis_pc_q;
    mis_tgt_d  = mis_tgt_q;
    mis_type_d = mis_type_q;
    if (mis_valid) begin
      mis_pc_d   = mis_pc;
      mis_tgt_d  = mis_target;
      mis_type_d = mis_type;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) pc_q[i] <= '0;
      taken_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      mis_vld_q  <= 1'b0;
      mis_pc_q   <= '0;
      mis_tgt_q  <= '0;
      mis_type_q <= '0;
    end else begin
      pc_q       <= pc_d;
      taken_q    <= taken_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      mis_vld_q  <= mis_vld_d;
      mis_pc_q   <= mis_pc_d;
      mis_tgt_q  <= mis_tgt_d;
      mis_type_q <= mis_type_d;
    end
  end

  assign ret_ready       = (free_slots >= CW'(2));
  assign update_orien_en = pop;
  assign retire_pc       = pop ? pc_q[head_q] : '0;
  assign right_orien     = pop ? taken_q[head_q] : 1'b0;

  assign branch_mistaken = mis_vld_q;
  assign wrong_pc        = mis_pc_q;
  assign right_target    = mis_tgt_q;
  assign ins_type_w      = mis_type_q;

`ifdef PRED_UPD_PERF_EN
  logic [CNTW-1:0] perf_drop_q, perf_drop_d;
  logic [CNTW-1:0] perf_full_q, perf_full_d;
  logic [1:0]      n_drop;
  logic [CNTW:0]   drop_sum;

  always_comb begin
    n_drop      = {1'b0, req0 & ~acc0} + {1'b0, req1 & ~acc1};
    drop_sum    = {1'b0, perf_drop_q} + {{(CNTW-1){1'b0}}, n_drop};
    perf_drop_d = drop_sum[CNTW] ? '1 : drop_sum[CNTW-1:0];
    perf_full_d = perf_full_q;
    if (!ret_ready && (perf_full_q != '1)) perf_full_d = perf_full_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_drop_q <= '0;
      perf_full_q <= '0;
    end else begin
      perf_drop_q <= perf_drop_d;
      perf_full_q <= perf_full_d;
    end
  end

  assign perf_drop = perf_drop_q;
  assign perf_full = perf_full_q;
`else
  assign perf_drop = '0;
  assign perf_full = '0;
`endif

endmodule
